// File: rtl/product_bcd_converter_pkg.sv
// -----------------------------------------------------------------------------
// product_bcd_pkg
// Shared definitions for the product_bcd_converter slice:
//   - state_e      : converter FSM states (IDLE / SHIFT / DONE)
//   - DIGIT_W      : width of one BCD digit
//   - ADD3_THRESH  : digit value at or above which double dabble adds 3
//   - DEF_DATA_W   : default binary input width
//   - DEF_DIGITS   : default number of BCD output digits
// -----------------------------------------------------------------------------
package product_bcd_pkg;

  localparam int          DIGIT_W     = 4;
  localparam logic [3:0]  ADD3_THRESH = 4'd5;
  localparam int          DEF_DATA_W  = 8;
  localparam int          DEF_DIGITS  = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/product_bcd_converter_if.sv
// -----------------------------------------------------------------------------
// product_bcd_converter_if
// Handshake bundle between the Multiplier side, the converter and the display
// stage.
//   son/in_valid/in_ready   : input handshake carrying the binary product
//   bcd/out_valid/out_ready : output handshake carrying packed BCD digits
//   blank                   : leading-zero mask (only with PRODUCT_BCD_BLANK_EN)
// Modports: master = producer/consumer side (testbench, neighbours),
//           slave  = the converter.
// -----------------------------------------------------------------------------
interface product_bcd_converter_if
  import product_bcd_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DIGITS = DEF_DIGITS
);

  logic [DATA_W-1:0]         son;
  logic                      in_valid;
  logic                      in_ready;
  logic                      out_valid;
  logic                      out_ready;
  logic [DIGIT_W*DIGITS-1:0] bcd;
`ifdef PRODUCT_BCD_BLANK_EN
  logic [DIGITS-1:0]         blank;

  modport master (output son, in_valid, out_ready,
                  input  in_ready, out_valid, bcd, blank);
  modport slave  (input  son, in_valid, out_ready,
                  output in_ready, out_valid, bcd, blank);
`else
  modport master (output son, in_valid, out_ready,
                  input  in_ready, out_valid, bcd);
  modport slave  (input  son, in_valid, out_ready,
                  output in_ready, out_valid, bcd);
`endif

endinterface

// File: rtl/product_bcd_converter_add3.sv
// -----------------------------------------------------------------------------
// bcd_add3
// Combinational double-dabble digit correction: a digit >= 5 gets +3 so that
// the following left shift carries correctly into the next decade.
//   din  : working BCD digit
//   dout : corrected digit
// -----------------------------------------------------------------------------
module bcd_add3
  import product_bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] din,
  output logic [DIGIT_W-1:0] dout
);

  // Conditional +3 correction
  always_comb begin
    dout = din;
    if (din >= ADD3_THRESH) begin
      dout = din + 4'd3;
    end else begin
      dout = din;
    end
  end

endmodule

// File: rtl/product_bcd_converter.sv
// -----------------------------------------------------------------------------
// product_bcd_converter
// Sequential binary-to-BCD converter (double dabble, one bit per clock).
// Accepts one unsigned product in IDLE, runs DATA_W shift iterations, then
// presents the digits in DONE until the consumer takes them.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : product_bcd_converter_if.slave (son/in_valid/in_ready,
//          bcd/out_valid/out_ready, blank)
// Optional feature: define PRODUCT_BCD_BLANK_EN to add the registered
// leading-zero mask `blank`.
// -----------------------------------------------------------------------------
module product_bcd_converter
  import product_bcd_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DIGITS = DEF_DIGITS
)(
  input  logic                    clk,
  input  logic                    rst,
  product_bcd_converter_if.slave  bus
);

  localparam int BCD_W = DIGIT_W * DIGITS;
  localparam int CNT_W = $clog2(DATA_W + 1);

  state_e                    state_r;
  state_e                    state_n;
  logic [DATA_W-1:0]         bin_r;
  logic [BCD_W-1:0]          bcd_work_r;
  logic [CNT_W-1:0]          cnt_r;
  logic [BCD_W-1:0]          bcd_out_r;
  logic                      in_ready_r;
  logic                      out_valid_r;
  logic                      in_ready_s;
  logic                      out_valid_s;
  logic [BCD_W-1:0]          corr_s;
  logic [BCD_W+DATA_W-1:0]   shift_s;
  logic                      last_iter_s;

  // Per-digit +3 correction of the working BCD register
  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (
      .din  (bcd_work_r[g*DIGIT_W +: DIGIT_W]),
      .dout (corr_s[g*DIGIT_W +: DIGIT_W])
    );
  end

  // Corrected digits and remaining binary shifted left as one word
  always_comb begin
    shift_s     = {corr_s, bin_r} << 1;
    last_iter_s = (cnt_r == CNT_W'(DATA_W - 1));
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_n;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_n = state_r;
    case (state_r)
      IDLE: begin
        if (bus.in_valid) state_n = SHIFT;
        else              state_n = IDLE;
      end
      SHIFT: begin
        if (last_iter_s) state_n = DONE;
        else             state_n = SHIFT;
      end
      DONE: begin
        if (bus.out_ready) state_n = IDLE;
        else               state_n = DONE;
      end
      default: state_n = IDLE;
    endcase
  end

  // FSM output decode; decoded from the next state so the flops below line up
  // with the state register
  always_comb begin
    in_ready_s  = (state_n == IDLE);
    out_valid_s = (state_n == DONE);
  end

  // Registered handshake outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      in_ready_r  <= in_ready_s;
      out_valid_r <= out_valid_s;
    end
  end

  // Working shift register and iteration counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bin_r      <= '0;
      bcd_work_r <= '0;
      cnt_r      <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.in_valid) begin
            bin_r      <= bus.son;
            bcd_work_r <= '0;
            cnt_r      <= '0;
          end
        end
        SHIFT: begin
          {bcd_work_r, bin_r} <= shift_s;
          cnt_r               <= cnt_r + CNT_W'(1);
        end
        default: begin
          cnt_r <= cnt_r;
        end
      endcase
    end
  end

  // Output digit register: loaded only with a finished conversion
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bcd_out_r <= '0;
    end else if ((state_r == SHIFT) && last_iter_s) begin
      bcd_out_r <= shift_s[DATA_W +: BCD_W];
    end
  end

`ifdef PRODUCT_BCD_BLANK_EN
  logic [DIGITS-1:0] blank_r;
  logic [DIGITS-1:0] blank_s;
  logic              zero_acc_s;

  // Leading-zero mask of the finished digits; ones digit is never blanked
  always_comb begin
    blank_s    = '0;
    zero_acc_s = 1'b1;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      zero_acc_s = zero_acc_s & (shift_s[DATA_W + k*DIGIT_W +: DIGIT_W] == 4'd0);
      blank_s[k] = zero_acc_s;
    end
  end

  // Blank mask register, loaded on the same edge as the digits
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blank_r <= {{(DIGITS-1){1'b1}}, 1'b0};
    end else if ((state_r == SHIFT) && last_iter_s) begin
      blank_r <= blank_s;
    end
  end

  assign bus.blank = blank_r;
`endif

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.bcd       = bcd_out_r;

endmodule

// File: tb/tb_product_bcd_converter.sv
// -----------------------------------------------------------------------------
// tb_product_bcd_converter
// Self-checking bench: directed scenarios plus randomized and exhaustive
// conversions compared with a decimal-arithmetic reference model.
// Define PRODUCT_BCD_BLANK_EN to also check the blank mask.
// -----------------------------------------------------------------------------
module tb_product_bcd_converter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   lat;

  product_bcd_converter_if #(.DATA_W(8), .DIGITS(3)) bus ();

  product_bcd_converter #(.DATA_W(8), .DIGITS(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference: decimal digits by plain division
  function automatic logic [11:0] ref_bcd(input int v);
    logic [3:0] h, t, o;
    h = 4'(v / 100);
    t = 4'((v / 10) % 10);
    o = 4'(v % 10);
    return {h, t, o};
  endfunction

  // Reference: digit k blanked when the value has fewer than k+1 digits
  function automatic logic [2:0] ref_blank(input int v);
    logic [2:0] b;
    b[0] = 1'b0;
    b[1] = (v < 10);
    b[2] = (v < 100);
    return b;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one value and wait for the accepting edge
  task automatic send(input int v);
    int guard;
    guard = 0;
    while (!bus.in_ready && guard < 100) begin
      tick();
      guard++;
    end
    check("in_ready_timeout", {31'd0, bus.in_ready}, 32'd1);
    bus.son      = 8'(v);
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
  endtask

  // Wait for out_valid; exp_lat counts edges from the call point
  task automatic wait_out(input string tag, input int v, input int exp_lat);
    int k;
    k = 0;
    while (!bus.out_valid && k < 50) begin
      tick();
      k++;
    end
    check({tag, "_latency"}, k, exp_lat);
    check({tag, "_bcd"}, {20'd0, bus.bcd}, {20'd0, ref_bcd(v)});
`ifdef PRODUCT_BCD_BLANK_EN
    check({tag, "_blank"}, {29'd0, bus.blank}, {29'd0, ref_blank(v)});
`endif
  endtask

  // Complete the output handshake; digits must stay put in IDLE
  task automatic release_out(input string tag, input int v);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check({tag, "_rel_valid"}, {31'd0, bus.out_valid}, 32'd0);
    check({tag, "_rel_ready"}, {31'd0, bus.in_ready}, 32'd1);
    check({tag, "_rel_hold"}, {20'd0, bus.bcd}, {20'd0, ref_bcd(v)});
  endtask

  task automatic convert(input string tag, input int v, input int hold);
    send(v);
    wait_out(tag, v, 8);
    for (int i = 0; i < hold; i++) begin
      tick();
      check({tag, "_bp_valid"}, {31'd0, bus.out_valid}, 32'd1);
      check({tag, "_bp_bcd"}, {20'd0, bus.bcd}, {20'd0, ref_bcd(v)});
    end
    release_out(tag, v);
  endtask

  initial begin
    bus.son       = 8'd0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Reset state
    check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_bcd", {20'd0, bus.bcd}, 32'd0);
`ifdef PRODUCT_BCD_BLANK_EN
    check("rst_blank", {29'd0, bus.blank}, 32'd6);
`endif

    // Directed values, including backpressure on 96
    convert("v225", 225, 0);
    convert("v0", 0, 0);
    convert("v7", 7, 0);
    convert("v96", 96, 20);

    // in_valid during SHIFT is ignored, accepted after the output handshake
    send(45);
    tick();
    tick();
    bus.son      = 8'd35;
    bus.in_valid = 1'b1;
    wait_out("ign45", 45, 6);
    release_out("ign45", 45);
    tick();
    bus.in_valid = 1'b0;
    check("acc35_in_ready", {31'd0, bus.in_ready}, 32'd0);
    wait_out("acc35", 35, 8);
    release_out("acc35", 35);

    // Reset during the 4th iteration of 117
    send(117);
    tick();
    tick();
    tick();
    #2;
    rst = 1'b1;
    #1;
    check("abort_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("abort_bcd", {20'd0, bus.bcd}, 32'd0);
    check("abort_in_ready", {31'd0, bus.in_ready}, 32'd1);
`ifdef PRODUCT_BCD_BLANK_EN
    check("abort_blank", {29'd0, bus.blank}, 32'd6);
`endif
    tick();
    rst = 1'b0;
    tick();
    check("post_abort_bcd", {20'd0, bus.bcd}, 32'd0);
    convert("v150", 150, 0);
    convert("v255", 255, 0);

    // Random values with random backpressure
    for (int i = 0; i < 40; i++) begin
      convert("rand", int'($urandom_range(255, 0)), int'($urandom_range(3, 0)));
    end

    // Exhaustive sweep
    for (int v = 0; v < 256; v++) begin
      send(v);
      wait_out("sweep", v, 8);
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
